// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the crossbar masters and the arbiter.
// master = requester side, slave = arbiter side.
interface bus_arbiter_if #(
    parameter int NUM_MASTERS = 16
) ();
    localparam int ID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] request;
    logic [NUM_MASTERS-1:0] done;
    logic [NUM_MASTERS-1:0] grant;
    logic                   grant_valid;
    logic [ID_W-1:0]        grant_id;
    logic                   timeout_err;

    modport master (
        output request,
        output done,
        input  grant,
        input  grant_valid,
        input  grant_id,
        input  timeout_err
    );

    modport slave (
        input  request,
        input  done,
        output grant,
        output grant_valid,
        output grant_id,
        output timeout_err
    );
endinterface

// File: rtl/bus_arbiter.sv
// N-master bus arbiter: fixed-priority or round-robin selection, grant held for a
// whole transaction, watchdog revokes grants held longer than TIMEOUT cycles.
module bus_arbiter #(
    parameter int NUM_MASTERS = 16,
    parameter int RR_MODE     = 1,
    parameter int TIMEOUT     = 256
) (
    input  logic         clk,
    input  logic         rst,
    bus_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_MASTERS);
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_MASTERS - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [ID_W-1:0]        grant_id_q;
    logic                   timeout_err_q;
    logic [ID_W-1:0]        rr_ptr_q;
    logic [ID_W-1:0]        rr_ptr_d;
    logic [WD_W-1:0]        wd_cnt_q;
    logic [WD_W-1:0]        wd_cnt_d;

    logic [ID_W-1:0]        scan_base;
    logic [ID_W-1:0]        cand;
    logic [ID_W-1:0]        win_id;
    logic                   win_found;

    logic                   hold_done;
    logic                   hold_req;
    logic                   wd_expire;
    logic                   release_now;
    logic                   wd_only;

    // Fixed mode always scans from index 0, which makes it plain lowest-index priority.
    assign scan_base = (RR_MODE != 0) ? rr_ptr_q : '0;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (int'(scan_base) + i >= NUM_MASTERS) begin
                cand = ID_W'(int'(scan_base) + i - NUM_MASTERS);
            end else begin
                cand = ID_W'(int'(scan_base) + i);
            end
            if (!win_found && bus.request[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign hold_done   = bus.done[grant_id_q];
    assign hold_req    = bus.request[grant_id_q];
    assign wd_expire   = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST);
    assign release_now = hold_done || !hold_req || wd_expire;
    // A done or withdrawal landing in the expiry cycle counts as a clean release.
    assign wd_only     = wd_expire && !hold_done && hold_req;

    assign rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_W'(1);
    assign wd_cnt_d = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + WD_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            timeout_err_q <= 1'b0;
            rr_ptr_q      <= '0;
            wd_cnt_q      <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        grant_q    <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win_id;
                        grant_id_q <= win_id;
                        wd_cnt_q   <= '0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        grant_q       <= '0;
                        grant_id_q    <= '0;
                        timeout_err_q <= wd_only;
                        state_q       <= IDLE;
                        if (RR_MODE != 0) begin
                            rr_ptr_q <= rr_ptr_d;
                        end
                    end else begin
                        wd_cnt_q <= wd_cnt_d;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    grant_q    <= '0;
                    grant_id_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = |grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a round-robin instance (TIMEOUT=8) and a fixed-priority
// instance (watchdog off) driven from per-scenario step tables.
module tb_bus_arbiter;
    logic clk;
    logic rst;

    bus_arbiter_if #(.NUM_MASTERS(16)) if_rr ();
    bus_arbiter_if #(.NUM_MASTERS(16)) if_fx ();

    bus_arbiter #(.NUM_MASTERS(16), .RR_MODE(1), .TIMEOUT(8)) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (if_rr.slave)
    );

    bus_arbiter #(.NUM_MASTERS(16), .RR_MODE(0), .TIMEOUT(0)) u_fx (
        .clk (clk),
        .rst (rst),
        .bus (if_fx.slave)
    );

    typedef struct packed {
        logic [15:0] g;
        logic [3:0]  id;
        logic        t;
    } exp_t;

    typedef struct {
        bit          sel;
        bit          r;
        logic [15:0] req;
        logic [15:0] dn;
        logic [15:0] g;
        logic [3:0]  id;
        logic        t;
    } step_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "bench timeout");
    end

    function automatic step_t mk(bit sel, bit r, logic [15:0] req, logic [15:0] dn,
                                 logic [15:0] g, logic [3:0] id, logic t);
        step_t s;
        s.sel = sel; s.r = r; s.req = req; s.dn = dn;
        s.g = g; s.id = id; s.t = t;
        return s;
    endfunction

    // Drives one cycle of inputs at a falling edge and samples outputs at the next one.
    task automatic drive_cycle(input bit sel, input bit r, input logic [15:0] req,
                               input logic [15:0] dn, output logic [15:0] g,
                               output logic [3:0] id, output logic v, output logic t);
        rst            = r;
        if_rr.request  = sel ? 16'h0 : req;
        if_rr.done     = sel ? 16'h0 : dn;
        if_fx.request  = sel ? req : 16'h0;
        if_fx.done     = sel ? dn : 16'h0;
        @(posedge clk);
        @(negedge clk);
        g  = sel ? if_fx.grant       : if_rr.grant;
        id = sel ? if_fx.grant_id    : if_rr.grant_id;
        v  = sel ? if_fx.grant_valid : if_rr.grant_valid;
        t  = sel ? if_fx.timeout_err : if_rr.timeout_err;
    endtask

    task automatic test_reset();
        step_t st[$];
        exp_t e; logic [15:0] g; logic [3:0] id; logic v, t;
        st.push_back(mk(0, 1, 16'hFFFF, 16'h0, 16'h0, 4'd0, 1'b0));
        st.push_back(mk(0, 1, 16'h0005, 16'h0, 16'h0, 4'd0, 1'b0));
        st.push_back(mk(1, 1, 16'hFFFF, 16'h0, 16'h0, 4'd0, 1'b0));
        st.push_back(mk(1, 1, 16'h0000, 16'h0, 16'h0, 4'd0, 1'b0));
        st.push_back(mk(0, 0, 16'h0000, 16'h0, 16'h0, 4'd0, 1'b0));
        foreach (st[i]) begin
            sb.push_back('{st[i].g, st[i].id, st[i].t});
            drive_cycle(st[i].sel, st[i].r, st[i].req, st[i].dn, g, id, v, t);
            e = sb.pop_front();
            vectors++;
            if (g !== e.g || id !== e.id || v !== (|e.g) || t !== e.t) begin
                miscompares++;
                $display("FAIL reset[%0d]: grant=%h id=%0d valid=%b terr=%b, required grant=%h id=%0d valid=%b terr=%b",
                         i, g, id, v, t, e.g, e.id, |e.g, e.t);
            end
        end
    endtask

    task automatic test_basic();
        step_t st[$];
        exp_t e; logic [15:0] g; logic [3:0] id; logic v, t;
        st.push_back(mk(0, 0, 16'h0005, 16'h0000, 16'h0001, 4'd0, 1'b0));
        st.push_back(mk(0, 0, 16'h0005, 16'h0001, 16'h0000, 4'd0, 1'b0));
        st.push_back(mk(0, 0, 16'h0004, 16'h0000, 16'h0004, 4'd2, 1'b0));
        st.push_back(mk(0, 0, 16'h0004, 16'h0004, 16'h0000, 4'd0, 1'b0));
        st.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0));
        foreach (st[i]) begin
            sb.push_back('{st[i].g, st[i].id, st[i].t});
            drive_cycle(st[i].sel, st[i].r, st[i].req, st[i].dn, g, id, v, t);
            e = sb.pop_front();
            vectors++;
            if (g !== e.g || id !== e.id || v !== (|e.g) || t !== e.t) begin
                miscompares++;
                $display("FAIL basic[%0d]: grant=%h id=%0d valid=%b terr=%b, required grant=%h id=%0d valid=%b terr=%b",
                         i, g, id, v, t, e.g, e.id, |e.g, e.t);
            end
        end
    endtask

    task automatic test_rr_fairness();
        step_t st[$];
        exp_t e; logic [15:0] g; logic [3:0] id; logic v, t;
        logic [15:0] oh;
        st.push_back(mk(0, 1, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0));
        for (int k = 0; k < 17; k++) begin
            oh = 16'h0001 << (k % 16);
            st.push_back(mk(0, 0, 16'hFFFF, 16'h0000, oh, 4'(k % 16), 1'b0));
            st.push_back(mk(0, 0, 16'hFFFF, oh, 16'h0000, 4'd0, 1'b0));
        end
        st.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0));
        foreach (st[i]) begin
            sb.push_back('{st[i].g, st[i].id, st[i].t});
            drive_cycle(st[i].sel, st[i].r, st[i].req, st[i].dn, g, id, v, t);
            e = sb.pop_front();
            vectors++;
            if (g !== e.g || id !== e.id || v !== (|e.g) || t !== e.t) begin
                miscompares++;
                $display("FAIL rr_fair[%0d]: grant=%h id=%0d valid=%b terr=%b, required grant=%h id=%0d valid=%b terr=%b",
                         i, g, id, v, t, e.g, e.id, |e.g, e.t);
            end
        end
    endtask

    task automatic test_fixed_priority();
        step_t st[$];
        exp_t e; logic [15:0] g; logic [3:0] id; logic v, t;
        for (int k = 0; k < 3; k++) begin
            st.push_back(mk(1, 0, 16'h8003, 16'h0000, 16'h0001, 4'd0, 1'b0));
            st.push_back(mk(1, 0, 16'h8003, 16'h0001, 16'h0000, 4'd0, 1'b0));
        end
        st.push_back(mk(1, 0, 16'h8000, 16'h0000, 16'h8000, 4'd15, 1'b0));
        st.push_back(mk(1, 0, 16'h8000, 16'h8000, 16'h0000, 4'd0, 1'b0));
        // Watchdog disabled: a long hold is never revoked.
        for (int k = 0; k < 20; k++) begin
            st.push_back(mk(1, 0, 16'h0006, 16'h0000, 16'h0002, 4'd1, 1'b0));
        end
        st.push_back(mk(1, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0));
        foreach (st[i]) begin
            sb.push_back('{st[i].g, st[i].id, st[i].t});
            drive_cycle(st[i].sel, st[i].r, st[i].req, st[i].dn, g, id, v, t);
            e = sb.pop_front();
            vectors++;
            if (g !== e.g || id !== e.id || v !== (|e.g) || t !== e.t) begin
                miscompares++;
                $display("FAIL fixed[%0d]: grant=%h id=%0d valid=%b terr=%b, required grant=%h id=%0d valid=%b terr=%b",
                         i, g, id, v, t, e.g, e.id, |e.g, e.t);
            end
        end
    endtask

    task automatic test_watchdog();
        step_t st[$];
        exp_t e; logic [15:0] g; logic [3:0] id; logic v, t;
        // Variant 0: pure expiry; 1: done in the 8th cycle; 2: withdrawal in the 8th cycle.
        for (int vr = 0; vr < 3; vr++) begin
            for (int k = 0; k < 8; k++) begin
                st.push_back(mk(0, 0, 16'h0002, 16'h0000, 16'h0002, 4'd1, 1'b0));
            end
            case (vr)
                0:       st.push_back(mk(0, 0, 16'h0002, 16'h0000, 16'h0000, 4'd0, 1'b1));
                1:       st.push_back(mk(0, 0, 16'h0002, 16'h0002, 16'h0000, 4'd0, 1'b0));
                default: st.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0));
            endcase
            st.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0));
        end
        foreach (st[i]) begin
            sb.push_back('{st[i].g, st[i].id, st[i].t});
            drive_cycle(st[i].sel, st[i].r, st[i].req, st[i].dn, g, id, v, t);
            e = sb.pop_front();
            vectors++;
            if (g !== e.g || id !== e.id || v !== (|e.g) || t !== e.t) begin
                miscompares++;
                $display("FAIL watchdog[%0d]: grant=%h id=%0d valid=%b terr=%b, required grant=%h id=%0d valid=%b terr=%b",
                         i, g, id, v, t, e.g, e.id, |e.g, e.t);
            end
        end
    endtask

    task automatic test_withdraw();
        step_t st[$];
        exp_t e; logic [15:0] g; logic [3:0] id; logic v, t;
        st.push_back(mk(0, 0, 16'h0008, 16'h0000, 16'h0008, 4'd3, 1'b0));
        st.push_back(mk(0, 0, 16'h0008, 16'h0020, 16'h0008, 4'd3, 1'b0));
        st.push_back(mk(0, 0, 16'h0008, 16'h0000, 16'h0008, 4'd3, 1'b0));
        st.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0));
        // Pointer now at 4: masters 3 and 5 requesting must pick 5.
        st.push_back(mk(0, 0, 16'h0028, 16'h0000, 16'h0020, 4'd5, 1'b0));
        st.push_back(mk(0, 0, 16'h002F, 16'h0000, 16'h0020, 4'd5, 1'b0));
        st.push_back(mk(0, 0, 16'h002F, 16'h0008, 16'h0020, 4'd5, 1'b0));
        st.push_back(mk(0, 0, 16'h002F, 16'h0020, 16'h0000, 4'd0, 1'b0));
        st.push_back(mk(0, 0, 16'h0000, 16'hFFFF, 16'h0000, 4'd0, 1'b0));
        st.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0));
        foreach (st[i]) begin
            sb.push_back('{st[i].g, st[i].id, st[i].t});
            drive_cycle(st[i].sel, st[i].r, st[i].req, st[i].dn, g, id, v, t);
            e = sb.pop_front();
            vectors++;
            if (g !== e.g || id !== e.id || v !== (|e.g) || t !== e.t) begin
                miscompares++;
                $display("FAIL withdraw[%0d]: grant=%h id=%0d valid=%b terr=%b, required grant=%h id=%0d valid=%b terr=%b",
                         i, g, id, v, t, e.g, e.id, |e.g, e.t);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        step_t st[$];
        exp_t e; logic [15:0] g; logic [3:0] id; logic v, t;
        st.push_back(mk(0, 0, 16'h0010, 16'h0000, 16'h0010, 4'd4, 1'b0));
        st.push_back(mk(0, 0, 16'h0010, 16'h0000, 16'h0010, 4'd4, 1'b0));
        st.push_back(mk(0, 1, 16'h0010, 16'h0000, 16'h0000, 4'd0, 1'b0));
        // Pointer back at 0: masters 4 and 7 requesting must pick 4.
        st.push_back(mk(0, 0, 16'h0090, 16'h0000, 16'h0010, 4'd4, 1'b0));
        st.push_back(mk(0, 0, 16'h0090, 16'h0010, 16'h0000, 4'd0, 1'b0));
        st.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0));
        foreach (st[i]) begin
            sb.push_back('{st[i].g, st[i].id, st[i].t});
            drive_cycle(st[i].sel, st[i].r, st[i].req, st[i].dn, g, id, v, t);
            e = sb.pop_front();
            vectors++;
            if (g !== e.g || id !== e.id || v !== (|e.g) || t !== e.t) begin
                miscompares++;
                $display("FAIL reset_mid[%0d]: grant=%h id=%0d valid=%b terr=%b, required grant=%h id=%0d valid=%b terr=%b",
                         i, g, id, v, t, e.g, e.id, |e.g, e.t);
            end
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        if_rr.request = '0;
        if_rr.done    = '0;
        if_fx.request = '0;
        if_fx.done    = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_rr_fairness();
        test_fixed_priority();
        test_watchdog();
        test_withdraw();
        test_reset_mid_grant();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Parametrised N-master bus arbiter for the crossbar front end; replaces the fixed 16-bit request/grant pair.
- Grants exactly one master at a time, holds the grant across a whole transaction and supports fixed-priority or round-robin selection.
- Adds a watchdog that forcibly revokes a grant held too long.
- Output grant vector drives the crossbar's master mux select.

Parameters:
- NUM_MASTERS, 16, number of requesters (2..64).
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (index 0 highest).
- TIMEOUT, 256, maximum cycles a grant may be held; 0 disables the watchdog.
- ID_W, $clog2(NUM_MASTERS), width of grant_id (derived, not overridden).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- request  input  NUM_MASTERS  level request per master; held until granted and served.
- done  input  NUM_MASTERS  one-cycle end-of-transaction pulse from the current holder.
- grant  output  NUM_MASTERS  registered one-hot grant, or all-zero.
- grant_valid  output  1  OR of grant.
- grant_id  output  ID_W  index of holder; 0 when idle.
- timeout_err  output  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (rst=1 at edge): grant=0, grant_valid=0, grant_id=0, timeout_err=0, state=IDLE, rr_ptr=0, wd_cnt=0. Reset overrides all activity, including mid-grant: grant is 0 after that edge.
- States: IDLE, BUSY.
- IDLE, any request bit set:
  - Fixed mode winner = lowest set index.
  - RR mode winner = first set index scanning rr_ptr, rr_ptr+1, … wrapping NUM_MASTERS-1 -> 0.
  - At the next edge: grant/grant_id register the winner, wd_cnt=0, state=BUSY.
  - Latency request->grant = 1 cycle.
- IDLE, no request: outputs stay 0.
- BUSY release conditions, evaluated each cycle for holder h:
  - done[h]=1, or
  - request[h]=0 (holder withdrew), or
  - watchdog expiry: TIMEOUT!=0 and wd_cnt==TIMEOUT-1.
- On release: at the next edge grant=0, grant_id=0, state=IDLE, rr_ptr=(h+1) mod NUM_MASTERS (RR mode only).
- After release there is one mandatory idle cycle before the next grant; minimum grant-to-grant spacing = holding time + 1.
- Without release: grant unchanged; wd_cnt increments and saturates.
- timeout_err: asserted for exactly one cycle, coincident with grant dropping, only when release is due to watchdog alone. done[h] or request[h] drop in the expiry cycle is a normal release with no error.
- done bits of non-holders are ignored. done while IDLE is ignored.
- Requests from other masters during BUSY never pre-empt the holder.
- Fixed mode: rr_ptr is never updated.
- Invariant: grant is one-hot or zero every cycle; grant_valid == |grant; grant_id is consistent with grant.

Test Plan:
- Reset, then request=0x0005, RR_MODE=1 -> cycle+1 grant=0x0001, grant_id=0. done[0] -> grant=0 for one cycle, then grant=0x0004, grant_id=2.
- RR fairness: request=0xFFFF held, done pulsed each grant -> grant_id sequence 0,1,2,…,15,0, each grant separated by exactly one idle cycle.
- Fixed priority (RR_MODE=0): request=0x8003 held, done each grant -> grant_id sequence 0,0,0; master 15 never granted while bit 0 is held.
- Watchdog, TIMEOUT=8: request=0x0002, no done -> grant=0x0002 for 8 cycles, then grant=0 with timeout_err=1 for one cycle. Same test with done[1] in the 8th cycle -> timeout_err stays 0.
- Withdraw and spurious done: holder 3 drops request[3] -> grant=0 next cycle, rr_ptr=4. done[5] pulsed while 3 holds -> no change.
- Reset mid-grant: assert rst while grant=0x0010 -> grant=0, grant_id=0 after that edge. After rst deasserts with request=0x0010 -> regranted with rr_ptr=0 scan.
